pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_if.sv | 51 +++++
 rtl/pipe_wdt.sv | 31 +++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Stall masks, eret code, default vector and FSM states.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WDT   = 2'd2
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] ERET_CODE      = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  // Deepest requesting stage wins.
  function automatic logic [5:0] stall_enc(
    input logic mem,
    input logic ex,
    input logic id,
    input logic fe
  );
    logic [5:0] s;
    priority case (1'b1)
      mem:     s = STALL_MEM;
      ex:      s = STALL_EX;
      id:      s = STALL_ID;
      fe:      s = STALL_IF;
      default: s = STALL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush bundle between pipeline stages and pipe_ctrl.
// stall_cycles exists only with PIPE_CTRL_PERF_EN.
interface pipe_ctrl_if;

  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdt_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  modport master (
`ifdef PIPE_CTRL_PERF_EN
    input  stall_cycles,
`endif
    output stallreq_if,
    output stallreq_id,
    output stallreq_ex,
    output stallreq_mem,
    output excepttype_i,
    output cp0_epc_i,
    input  stall,
    input  flush,
    input  new_pc,
    input  wdt_timeout
  );

  modport slave (
`ifdef PIPE_CTRL_PERF_EN
    output stall_cycles,
`endif
    input  stallreq_if,
    input  stallreq_id,
    input  stallreq_ex,
    input  stallreq_mem,
    input  excepttype_i,
    input  cp0_epc_i,
    output stall,
    output flush,
    output new_pc,
    output wdt_timeout
  );

endinterface

// File: rtl/pipe_wdt.sv
// Stall watchdog: saturating stall_cnt plus limit compare.
// Priority clr > load > inc.
module pipe_wdt #(
  parameter int WDT_W     = 8,
  parameter int WDT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic hit
);

  logic [WDT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
    end else if (load) begin
      stall_cnt <= WDT_W'(1);
    end else if (inc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hit = (stall_cnt == WDT_W'(WDT_LIMIT));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with stall watchdog.
// Optional PIPE_CTRL_PERF_EN adds a stall_cycles counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          WDT_W      = 8,
  parameter int          WDT_LIMIT  = 255,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  state_t      state;
  state_t      state_nx;
  logic        any_req;
  logic        exc;
  logic        hit;
  logic        cnt_clr;
  logic        cnt_load;
  logic        cnt_inc;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] pc_c;
  logic        wdt_c;
  logic [5:0]  req_mask;

  assign any_req = bus.stallreq_if | bus.stallreq_id
                 | bus.stallreq_ex | bus.stallreq_mem;
  assign exc = |bus.excepttype_i;
  assign req_mask = stall_enc(bus.stallreq_mem, bus.stallreq_ex,
                              bus.stallreq_id, bus.stallreq_if);

  pipe_wdt #(
    .WDT_W    (WDT_W),
    .WDT_LIMIT(WDT_LIMIT)
  ) u_wdt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .load(cnt_load),
    .inc (cnt_inc),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    stall_c  = STALL_NONE;
    flush_c  = 1'b0;
    pc_c     = 32'h0;
    wdt_c    = 1'b0;
    if (exc) begin
      flush_c  = 1'b1;
      pc_c     = (bus.excepttype_i == ERET_CODE)
               ? bus.cp0_epc_i : EXC_VECTOR;
      wdt_c    = (state == ST_WDT);
      state_nx = ST_RUN;
      cnt_clr  = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          stall_c = req_mask;
          if (any_req) begin
            state_nx = ST_STALL;
            cnt_load = 1'b1;
          end else begin
            cnt_clr = 1'b1;
          end
        end
        ST_STALL: begin
          stall_c = req_mask;
          if (!any_req) begin
            state_nx = ST_RUN;
            cnt_clr  = 1'b1;
          end else if (hit) begin
            state_nx = ST_WDT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_WDT: begin
          flush_c  = 1'b1;
          pc_c     = EXC_VECTOR;
          wdt_c    = 1'b1;
          state_nx = ST_RUN;
          cnt_clr  = 1'b1;
        end
        default: begin
          state_nx = ST_RUN;
          cnt_clr  = 1'b1;
        end
      endcase
    end
  end

  // Outputs are held quiet for as long as reset is low.
  assign bus.stall       = rst ? stall_c : STALL_NONE;
  assign bus.flush       = rst & flush_c;
  assign bus.new_pc      = rst ? pc_c : 32'h0;
  assign bus.wdt_timeout = rst & wdt_c;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.stall_cycles <= '0;
    end else if ((|bus.stall) && (bus.stall_cycles != '1)) begin
      bus.stall_cycles <= bus.stall_cycles + 32'd1;
    end
  end
`endif

endmodule
